// File: rtl/draw_scheduler_pkg.sv
// rtl/draw_scheduler_pkg.sv - shared state encodings, coordinate widths and defaults for the draw scheduler and drawers
package draw_scheduler_pkg;

    localparam int X_W  = 8;
    localparam int Y_W  = 7;
    localparam int C_W  = 3;
    localparam int ST_W = 3;

    localparam int FRAMES_PER_STEP_DEF = 4;
    localparam int DRAW_TIMEOUT_DEF    = 20000;

    // Plain constants rather than an enum so existing drawers and
    // debug tooling can keep comparing raw 3-bit codes.
    localparam logic [ST_W-1:0] ST_IDLE       = 3'd0;
    localparam logic [ST_W-1:0] ST_WAIT_FRAME = 3'd1;
    localparam logic [ST_W-1:0] ST_ERASE      = 3'd2;
    localparam logic [ST_W-1:0] ST_UPDATE     = 3'd3;
    localparam logic [ST_W-1:0] ST_DRAW_WALL  = 3'd4;
    localparam logic [ST_W-1:0] ST_DRAW_BIRD  = 3'd5;
    localparam logic [ST_W-1:0] ST_CHECK      = 3'd6;
    localparam logic [ST_W-1:0] ST_GAME_OVER  = 3'd7;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [C_W-1:0] colour;
        logic           plot;
    } pixel_t;

    function automatic pixel_t make_pixel(input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                                          input logic [C_W-1:0] colour, input logic plot);
        pixel_t p;
        p.x      = x;
        p.y      = y;
        p.colour = colour;
        p.plot   = plot;
        return p;
    endfunction

endpackage

// File: rtl/draw_scheduler_if.sv
// rtl/draw_scheduler_if.sv - drawer handshake and shared VGA port bundle
// master: scheduler side (drives starts and vga_*, reads dones and drawer pixels)
// slave:  drawer/adapter side
interface draw_scheduler_if;
    import draw_scheduler_pkg::*;

    logic           clear_start, wall_start, bird_start;
    logic           clear_done,  wall_done,  bird_done;

    logic [X_W-1:0] clear_x,      wall_x,      bird_x;
    logic [Y_W-1:0] clear_y,      wall_y,      bird_y;
    logic [C_W-1:0] clear_colour, wall_colour, bird_colour;
    logic           clear_plot,   wall_plot,   bird_plot;

    logic [X_W-1:0] vga_x;
    logic [Y_W-1:0] vga_y;
    logic [C_W-1:0] vga_colour;
    logic           vga_plot;

    modport master (
        output clear_start, wall_start, bird_start,
        input  clear_done,  wall_done,  bird_done,
        input  clear_x, clear_y, clear_colour, clear_plot,
        input  wall_x,  wall_y,  wall_colour,  wall_plot,
        input  bird_x,  bird_y,  bird_colour,  bird_plot,
        output vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        input  clear_start, wall_start, bird_start,
        output clear_done,  wall_done,  bird_done,
        output clear_x, clear_y, clear_colour, clear_plot,
        output wall_x,  wall_y,  wall_colour,  wall_plot,
        output bird_x,  bird_y,  bird_colour,  bird_plot,
        input  vga_x, vga_y, vga_colour, vga_plot
    );

endinterface

// File: rtl/draw_scheduler_frame_divider.sv
// rtl/draw_scheduler_frame_divider.sv - frame tick counter with clear and terminal-count pulse
// clk/reset: clock, sync active-high reset
// clear: hold count at zero; tick: frame pulse; tc: high on the TERMINAL-th tick
module frame_divider
    import draw_scheduler_pkg::*;
#(
    parameter int TERMINAL = FRAMES_PER_STEP_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic tc
);

    logic [3:0] count;

    // Gated by clear so ticks seen while the scheduler is elsewhere never count.
    assign tc = tick && !clear && (count == 4'(TERMINAL - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= 4'd0;
        end else if (tick) begin
            count <= tc ? 4'd0 : count + 4'd1;
        end
    end

endmodule

// File: rtl/draw_scheduler.sv
// rtl/draw_scheduler.sv - game step sequencer: frame pacing, drawer start/done handshakes, VGA mux
// clk/reset: clock, sync active-high reset
// frame_tick: per-frame pulse; go: player key (level); collision: sampled in CHECK only
// bus: drawer starts/dones/pixels and shared VGA port
// update_en: position advance pulse; cur_state: state code; game_over; timeout_err (sticky)
module draw_scheduler
    import draw_scheduler_pkg::*;
#(
    parameter int FRAMES_PER_STEP = FRAMES_PER_STEP_DEF,
    parameter int DRAW_TIMEOUT    = DRAW_TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            frame_tick,
    input  logic            go,
    input  logic            collision,
    draw_scheduler_if.master bus,
    output logic            update_en,
    output logic [ST_W-1:0] cur_state,
    output logic            game_over,
    output logic            timeout_err
);

    localparam int CW = (DRAW_TIMEOUT > 1) ? $clog2(DRAW_TIMEOUT) : 1;

    logic [ST_W-1:0] state, next_state;
    logic            go_q;
    logic            first_q;
    logic [CW-1:0]   phase_cnt;
    logic            timeout_q;

    logic            go_rise;
    logic            frame_tc;
    logic            is_draw;
    logic            done_sel;
    logic            done_ok;
    logic            phase_to;
    logic            advance;
    logic            live;
    pixel_t          px;

    assign go_rise = go && !go_q;
    assign is_draw = (state == ST_ERASE) || (state == ST_DRAW_WALL) || (state == ST_DRAW_BIRD);

    frame_divider #(.TERMINAL(FRAMES_PER_STEP)) u_frame_divider (
        .clk   (clk),
        .reset (reset),
        .clear (state != ST_WAIT_FRAME),
        .tick  (frame_tick),
        .tc    (frame_tc)
    );

    always_comb begin
        done_sel = 1'b0;
        case (state)
            ST_ERASE:     done_sel = bus.clear_done;
            ST_DRAW_WALL: done_sel = bus.wall_done;
            ST_DRAW_BIRD: done_sel = bus.bird_done;
            default:      done_sel = 1'b0;
        endcase
    end

    // A done in the start cycle belongs to the previous job of that drawer.
    assign done_ok  = is_draw && !first_q && done_sel;
    assign phase_to = is_draw && (phase_cnt == CW'(DRAW_TIMEOUT - 1));
    assign advance  = done_ok || phase_to;

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:       if (go_rise)  next_state = ST_WAIT_FRAME;
            ST_WAIT_FRAME: if (frame_tc) next_state = ST_ERASE;
            ST_ERASE:      if (advance)  next_state = ST_UPDATE;
            ST_UPDATE:                   next_state = ST_DRAW_WALL;
            ST_DRAW_WALL:  if (advance)  next_state = ST_DRAW_BIRD;
            ST_DRAW_BIRD:  if (advance)  next_state = ST_CHECK;
            ST_CHECK:      next_state = collision ? ST_GAME_OVER : ST_WAIT_FRAME;
            ST_GAME_OVER:  if (go_rise)  next_state = ST_IDLE;
            default:                     next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            go_q      <= 1'b0;
            first_q   <= 1'b0;
            phase_cnt <= '0;
            timeout_q <= 1'b0;
        end else begin
            state     <= next_state;
            go_q      <= go;
            first_q   <= (next_state != state);
            phase_cnt <= ((next_state != state) || !is_draw) ? '0 : phase_cnt + CW'(1);
            if (phase_to && !done_ok) begin
                timeout_q <= 1'b1;
            end
        end
    end

    // Pulses are masked while reset is held so an aborted phase cannot
    // kick a drawer in the reset cycle itself.
    assign live            = !reset;
    assign bus.clear_start = live && first_q && (state == ST_ERASE);
    assign bus.wall_start  = live && first_q && (state == ST_DRAW_WALL);
    assign bus.bird_start  = live && first_q && (state == ST_DRAW_BIRD);
    assign update_en       = live && (state == ST_UPDATE);

    assign cur_state   = state;
    assign game_over   = (state == ST_GAME_OVER);
    assign timeout_err = timeout_q;

    always_comb begin
        px = '0;
        case (state)
            ST_ERASE:     px = make_pixel(bus.clear_x, bus.clear_y, bus.clear_colour, bus.clear_plot);
            ST_DRAW_WALL: px = make_pixel(bus.wall_x,  bus.wall_y,  bus.wall_colour,  bus.wall_plot);
            ST_DRAW_BIRD: px = make_pixel(bus.bird_x,  bus.bird_y,  bus.bird_colour,  bus.bird_plot);
            default:      px = '0;
        endcase
    end

    assign bus.vga_x      = px.x;
    assign bus.vga_y      = px.y;
    assign bus.vga_colour = px.colour;
    assign bus.vga_plot   = px.plot;

endmodule

// File: tb/tb_draw_scheduler.sv
// tb/tb_draw_scheduler.sv - scoreboard bench for draw_scheduler
module tb_draw_scheduler;
    import draw_scheduler_pkg::*;

    localparam int FPS = 4;
    localparam int TO  = 64;

    localparam logic [2:0] K_STATE = 3'd0;
    localparam logic [2:0] K_CLR   = 3'd1;
    localparam logic [2:0] K_WALL  = 3'd2;
    localparam logic [2:0] K_BIRD  = 3'd3;
    localparam logic [2:0] K_UPD   = 3'd4;

    typedef struct packed {
        logic [2:0]  kind;
        logic [2:0]  val;
        logic [31:0] at;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset, frame_tick, go, collision;
    logic       update_en, game_over, timeout_err;
    logic [2:0] cur_state;

    draw_scheduler_if bus();

    draw_scheduler #(.FRAMES_PER_STEP(FPS), .DRAW_TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .go          (go),
        .collision   (collision),
        .bus         (bus),
        .update_en   (update_en),
        .cur_state   (cur_state),
        .game_over   (game_over),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;
    bit  mon_en   = 1'b0;
    bit  hooks    = 1'b0;
    logic [2:0] last_state = 3'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    endtask

    function automatic void expect_ev(input logic [2:0] kind, input logic [2:0] val, input int unsigned at);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.at   = at;
        exp_q.push_back(e);
    endfunction

    task automatic observe(input logic [2:0] kind, input logic [2:0] val);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL event: unexpected kind %0d state %0d at cycle %0d", kind, val, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind == kind && e.val == val && e.at == cyc) n_pass++;
            else $display("FAIL event: got kind %0d state %0d cycle %0d want kind %0d state %0d cycle %0d",
                          kind, val, cyc, e.kind, e.val, e.at);
        end
    endtask

    // Monitor: every state change and every start/update pulse cycle is one event.
    always @(negedge clk) begin
        if (mon_en) begin
            if (cur_state !== last_state) observe(K_STATE, cur_state);
            if (bus.clear_start) observe(K_CLR,  cur_state);
            if (bus.wall_start)  observe(K_WALL, cur_state);
            if (bus.bird_start)  observe(K_BIRD, cur_state);
            if (update_en)       observe(K_UPD,  cur_state);
        end
        last_state = cur_state;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int unsigned k);
        while (cyc < k) step();
    endtask

    task automatic set_done(input int sel, input logic v);
        case (sel)
            0:       bus.clear_done = v;
            1:       bus.wall_done  = v;
            default: bus.bird_done  = v;
        endcase
    endtask

    task automatic hook(input logic [2:0] st);
        if (st == ST_DRAW_WALL) begin
            go = 1'b1;
            collision = 1'b1;
            bus.wall_x = 8'h55; bus.wall_y = 7'h2a; bus.wall_colour = 3'd5; bus.wall_plot = 1'b1;
            bus.bird_x = 8'h22; bus.bird_y = 7'h11; bus.bird_colour = 3'd3; bus.bird_plot = 1'b1;
            bus.clear_x = 8'h77; bus.clear_y = 7'h33; bus.clear_colour = 3'd1; bus.clear_plot = 1'b1;
            @(negedge clk);
            check("vga_x_wall",      bus.vga_x,      8'h55);
            check("vga_y_wall",      bus.vga_y,      7'h2a);
            check("vga_colour_wall", bus.vga_colour, 3'd5);
            check("vga_plot_wall",   bus.vga_plot,   1'b1);
            step();
            go = 1'b0;
        end else if (st == ST_DRAW_BIRD) begin
            collision = 1'b0;
            frame_tick = 1'b1;
            bus.clear_done = 1'b1;
            bus.wall_done = 1'b1;
            @(negedge clk);
            check("vga_x_bird", bus.vga_x, 8'h22);
            step();
            frame_tick = 1'b0;
            bus.clear_done = 1'b0;
            bus.wall_done = 1'b0;
        end
    endtask

    // Entered with cyc equal to the first cycle in st; dly<0 means never send done.
    task automatic do_phase(input logic [2:0] st, input logic [2:0] nxt, input int sel, input int dly);
        int unsigned e, nx;
        e  = cyc;
        nx = (dly >= 0) ? e + dly + 1 : e + TO;
        expect_ev(K_STATE, nxt, nx);
        if (nxt == ST_UPDATE) begin
            expect_ev(K_UPD,   ST_UPDATE,    nx);
            expect_ev(K_STATE, ST_DRAW_WALL, nx + 1);
            expect_ev(K_WALL,  ST_DRAW_WALL, nx + 1);
        end
        if (nxt == ST_DRAW_BIRD) expect_ev(K_BIRD, ST_DRAW_BIRD, nx);
        set_done(sel, 1'b1);
        step();
        set_done(sel, 1'b0);
        if (hooks) hook(st);
        if (dly >= 0) begin
            wait_until(e + dly);
            set_done(sel, 1'b1);
            step();
            set_done(sel, 1'b0);
        end else begin
            wait_until(e + TO);
        end
        if (nxt == ST_UPDATE) step();
    endtask

    task automatic game_step(input int dc, input int dw, input int db, input logic coll, input bit abort);
        for (int i = 0; i < FPS; i++) begin
            if (i == FPS - 1) begin
                expect_ev(K_STATE, ST_ERASE, cyc + 1);
                expect_ev(K_CLR,   ST_ERASE, cyc + 1);
            end
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
            if (i < FPS - 1) begin
                step();
                step();
            end
        end
        do_phase(ST_ERASE,     ST_UPDATE,    0, dc);
        do_phase(ST_DRAW_WALL, ST_DRAW_BIRD, 1, dw);
        if (abort) return;
        do_phase(ST_DRAW_BIRD, ST_CHECK,     2, db);
        expect_ev(K_STATE, coll ? ST_GAME_OVER : ST_WAIT_FRAME, cyc + 1);
        collision = coll;
        step();
        collision = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; frame_tick = 1'b0; go = 1'b0; collision = 1'b0;
        bus.clear_done = 1'b0; bus.wall_done = 1'b0; bus.bird_done = 1'b0;
        bus.clear_x = '0; bus.clear_y = '0; bus.clear_colour = '0; bus.clear_plot = 1'b0;
        bus.wall_x  = '0; bus.wall_y  = '0; bus.wall_colour  = '0; bus.wall_plot  = 1'b0;
        bus.bird_x  = '0; bus.bird_y  = '0; bus.bird_colour  = '0; bus.bird_plot  = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        step();
        check("rst_state",       cur_state,   ST_IDLE);
        check("rst_game_over",   game_over,   1'b0);
        check("rst_timeout_err", timeout_err, 1'b0);
        check("rst_update_en",   update_en,   1'b0);
        check("rst_starts",      {bus.clear_start, bus.wall_start, bus.bird_start}, 3'b000);
        check("rst_vga_plot",    bus.vga_plot, 1'b0);
        mon_en = 1'b1;

        // Frame ticks in IDLE are not accumulated.
        repeat (3) begin
            frame_tick = 1'b1; step(); frame_tick = 1'b0; step();
        end

        go = 1'b1;
        expect_ev(K_STATE, ST_WAIT_FRAME, cyc + 1);
        repeat (3) step();
        go = 1'b0;
        step();

        // Full step, dones 10 cycles after each start, mid-phase disturbances.
        hooks = 1'b1;
        game_step(10, 10, 10, 1'b0, 1'b0);
        hooks = 1'b0;
        check("wait_state",      cur_state,    ST_WAIT_FRAME);
        check("wait_vga_plot",   bus.vga_plot, 1'b0);
        check("wait_vga_x",      bus.vga_x,    8'h00);
        check("no_timeout_yet",  timeout_err,  1'b0);

        // Collision only in CHECK -> GAME_OVER.
        game_step(2, 3, 2, 1'b1, 1'b0);
        check("game_over_set", game_over, 1'b1);
        go = 1'b1;
        expect_ev(K_STATE, ST_IDLE, cyc + 1);
        repeat (50) step();
        go = 1'b0;
        step();
        check("idle_after_go",   cur_state, ST_IDLE);
        check("game_over_clear", game_over, 1'b0);

        // Wall drawer never finishes -> forced advance after TO cycles.
        go = 1'b1;
        expect_ev(K_STATE, ST_WAIT_FRAME, cyc + 1);
        step();
        go = 1'b0;
        step();
        game_step(3, -1, 2, 1'b0, 1'b0);
        check("timeout_err_set",   timeout_err, 1'b1);
        step();
        step();
        check("timeout_err_stick", timeout_err, 1'b1);

        // Reset in DRAW_BIRD aborts the step.
        game_step(2, 4, 0, 1'b0, 1'b1);
        repeat (3) step();
        reset = 1'b1;
        expect_ev(K_STATE, ST_IDLE, cyc + 1);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("abort_state",       cur_state,   ST_IDLE);
        check("abort_timeout_err", timeout_err, 1'b0);
        check("abort_game_over",   game_over,   1'b0);
        check("abort_vga_plot",    bus.vga_plot, 1'b0);
        check("abort_update_en",   update_en,   1'b0);
        step();
        bus.bird_done = 1'b1;
        frame_tick = 1'b1;
        step();
        bus.bird_done = 1'b0;
        frame_tick = 1'b0;
        repeat (5) step();
        check("post_abort_state", cur_state, ST_IDLE);
        check("events_pending", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/draw_scheduler.md
DRAW_SCHEDULER -- requirements
Module: draw_scheduler

Interface
REQ-001 Parameter FRAMES_PER_STEP, default 4: frame ticks counted per game step (valid 1..15).
REQ-002 Parameter DRAW_TIMEOUT, default 20000: max cycles allowed per draw phase before forced advance.
REQ-003 clk  in  1  system clock; the block uses one clock and all logic is on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 frame_tick  in  1  one-cycle pulse per VGA frame.
REQ-006 go  in  1  player key, level; the block detects the rising edge internally.
REQ-007 collision  in  1  bird/wall overlap flag from the collision datapath.
REQ-008 clear_done, wall_done, bird_done  in  1 each  drawer completion pulses.
REQ-009 clear_x/wall_x/bird_x  in  8; clear_y/wall_y/bird_y  in  7; *_colour  in  3; *_plot  in  1: drawer pixel outputs.
REQ-010 clear_start, wall_start, bird_start  out  1 each  one-cycle drawer start pulses.
REQ-011 update_en  out  1  one-cycle pulse advancing bird/wall positions.
REQ-012 vga_x  out  8, vga_y  out  7, vga_colour  out  3, vga_plot  out  1  shared VGA adapter port.
REQ-013 cur_state  out  3  current state encoding; game_over  out  1; timeout_err  out  1 sticky.

Function
REQ-014 States: IDLE, WAIT_FRAME, ERASE, UPDATE, DRAW_WALL, DRAW_BIRD, CHECK, GAME_OVER.
REQ-015 IDLE -> WAIT_FRAME on go rising edge; the frame counter clears on entry.
REQ-016 WAIT_FRAME counts frame_tick; on the FRAMES_PER_STEP-th tick, next cycle -> ERASE.
REQ-017 frame_tick outside WAIT_FRAME is ignored (not accumulated).
REQ-018 ERASE/DRAW_WALL/DRAW_BIRD pulse their start output in the first cycle in state only.
REQ-019 A done pulse is honoured from the cycle after start; done coincident with start is ignored.
REQ-020 Transitions: ERASE -> UPDATE on clear_done; DRAW_WALL -> DRAW_BIRD on wall_done; DRAW_BIRD -> CHECK on bird_done.
REQ-021 UPDATE lasts exactly one cycle with update_en=1, then -> DRAW_WALL.
REQ-022 CHECK lasts one cycle: collision=1 -> GAME_OVER, else -> WAIT_FRAME with the counter cleared.
REQ-023 collision is sampled only in CHECK; its value in other states has no effect.
REQ-024 GAME_OVER holds game_over=1; go rising edge -> IDLE with game_over cleared.
REQ-025 The phase cycle counter resets on entry to each draw phase.
REQ-026 If a draw phase reaches DRAW_TIMEOUT cycles without done, the FSM advances as if done and sets timeout_err.
REQ-027 timeout_err is cleared only by reset.
REQ-028 VGA mux is combinational from state: ERASE->clear_*, DRAW_WALL->wall_*, DRAW_BIRD->bird_*.
REQ-029 In all other states vga_plot=0 and vga_x/vga_y/vga_colour=0.
REQ-030 go edge detection uses a registered copy of go; go held high yields one edge only.
REQ-031 A go edge in any state other than IDLE or GAME_OVER is ignored.

Reset
REQ-032 Reset state is IDLE, and cur_state equals the IDLE encoding.
REQ-033 On reset: all start pulses=0, update_en=0, game_over=0, timeout_err=0, counters=0, registered go=0.
REQ-034 Reset asserted mid-phase aborts the phase; no start or update pulse is issued in the reset cycle or the cycle after it.

Structure
REQ-035 State encodings, coordinate widths (X 8, Y 7, colour 3) and default parameters belong in a shared header (draw_defs.vh), included by the drawers as well.
REQ-036 One sub-module, frame_divider, SHALL provide the frame tick counter with clear and terminal-count output.

Verification
REQ-037 Reset, then go pulse, then 4 frame_ticks -> ERASE entered one cycle after the 4th tick; clear_start=1 for exactly 1 cycle.
REQ-038 Full step with dones 10 cycles after each start and collision=0 -> state sequence ERASE, UPDATE(1 cycle), DRAW_WALL, DRAW_BIRD, CHECK, WAIT_FRAME; update_en pulses once.
REQ-039 wall_x=0x55, wall_plot=1, bird_plot=1 during DRAW_WALL -> vga_x=0x55, bird pixels are not passed; in WAIT_FRAME vga_plot=0.
REQ-040 collision=1 only during CHECK -> GAME_OVER, game_over=1; go held high for 50 cycles -> IDLE once, stays IDLE.
REQ-041 wall_done never asserted -> DRAW_BIRD entered after DRAW_TIMEOUT cycles and timeout_err=1 until reset.
REQ-042 reset asserted in DRAW_BIRD -> IDLE next cycle, all outputs at reset values; frame_tick and done pulses during drawing are ignored.
